joypad_scanner: RTL and testbench
=================================

// Module: joypad_scanner
// PURPOSE
// - Scans two physical NES controllers (4021 shift-register pads) on the shared latch/clock lines.
// - Delivers debounced, active-high button vectors o_jp_vec_1p/o_jp_vec_2p.
// - These outputs feed i_jp_vec_1p/i_jp_vec_2p of nes_console, which passes them to joypad_ctrl and ppu_2C02.
// - Runs on i_clk (board clock for the console side).
// - The vector outputs are quasi-static (they change at most once per scan).
// PARAMETERS
// - CLK_DIV   default 12     i_clk cycles per pad-clock half period (>=2)
// - SCAN_GAP  default 30000  i_clk cycles from the end of one scan to the next latch (>=1)
// - DEB_CNT   default 2      number of consecutive identical scans required before a vector updates (1..7)
// PORTS
// - i_clk         in   1   clock
// - i_rst         in   1   asynchronous reset, active-high
// - o_pad_latch   out  1   shared latch to both pads, active-high
// - o_pad_clk     out  1   shared pad clock, idles high
// - i_pad_data_1p in   1   pad-1 serial data, active-low
// - i_pad_data_2p in   1   pad-2 serial data, active-low
// - i_turbo_1p    in   2   pad-1 turbo switches {B,A}, active-high (used only with JPD_TURBO_EN)
// - i_turbo_2p    in   2   pad-2 turbo switches {B,A}, active-high (used only with JPD_TURBO_EN)
// - o_jp_vec_1p   out  10  pad-1 vector {TB,TA,R,L,D,U,Start,Select,B,A}; 1 = pressed
// - o_jp_vec_2p   out  10  pad-2 vector, same bit map
// - o_scan_done   out  1   one-cycle pulse when a scan completes
// BEHAVIOUR
// - Reset: outputs o_pad_latch=0, o_pad_clk=1, o_jp_vec_*=0, o_scan_done=0.
//   Internal state: FSM=GAP, all counters=0, debounce history cleared.
// - Reset can be asserted mid-scan. The scan aborts immediately and the pad lines return to idle.
//   The pads resync on the next latch.
// - Pad data passes through a 2-FF synchronizer and is inverted at capture, so a captured bit of 1 means pressed.
// - FSM states:
//   - GAP: count SCAN_GAP cycles, then go to LATCH.
//   - LATCH: drive o_pad_latch=1 for 2*CLK_DIV cycles, then drop it and go to SETTLE.
//   - SETTLE: wait CLK_DIV cycles, then go to SAMPLE.
//   - SAMPLE: one cycle. Capture both pads at bit index n (0..7, order A,B,Sel,Start,U,D,L,R).
//     If n==7 go to DONE, else go to CLK_LO.
//   - CLK_LO: drive o_pad_clk=0 for CLK_DIV cycles, then go to CLK_HI.
//   - CLK_HI: drive o_pad_clk=1 for CLK_DIV cycles. The rising edge shifts the pad.
//     Then n=n+1 and go to SAMPLE.
//   - DONE: one cycle. Assert o_scan_done, run the debounce update, then go to GAP.
// - Each scan produces exactly 7 pad-clock low pulses.
// - Latency from latch rising to DONE = 2*CLK_DIV + CLK_DIV + 8 + 7*2*CLK_DIV + 1 cycles.
//   With the default CLK_DIV=12 this is 213 cycles.
// - Bit counter is 3 bits. Advancing past 7 is impossible because SAMPLE exits at n==7.
// - Debounce (in DONE):
//   - Per pad, compare the raw 8-bit capture with the previous raw capture.
//   - If equal, the matching-scan count increments, saturating at DEB_CNT. If different, it reloads to 1.
//   - Vector bits [7:0] update in DONE when the count (after that update) equals DEB_CNT.
//   - The vector is written atomically, all 8 bits in the same cycle.
// - Opposite directions:
//   - If the debounced U&D are both set, both are output as 0.
//   - If L&R are both set, both are output as 0.
//   - Other bits are unaffected.
// - Disconnected pad (data floats high) reads as all released, i.e. vector 0.
// CONFIGURATION
// - Macro JPD_TURBO_EN.
// - Defined:
//   - A 4-bit rate counter increments in every DONE cycle.
//   - Its MSB is the turbo phase, giving a 16-scan period.
//   - o_jp_vec_xp[8] = i_turbo_xp[0] & phase; o_jp_vec_xp[9] = i_turbo_xp[1] & phase.
//   - Both update in the DONE cycle.
// - Undefined:
//   - Bits [9:8] are tied to 0.
//   - i_turbo_* are unused and no rate counter exists.
// TESTING
// - Pad model: 4021-style. latch=1 loads; each o_pad_clk rising edge shifts; data active-low.
// - T1: pad1 holds A+Start (0x09), pad2 holds Right (0x80), DEB_CNT=2, two scans.
//   -> after the 2nd o_scan_done, o_jp_vec_1p=10'h009 and o_jp_vec_2p=10'h080.
//   -> after the 1st o_scan_done, both vectors are still 0.
// - T2: one scan. -> exactly 7 o_pad_clk low pulses; latch high for 24 cycles (CLK_DIV=12).
//   -> o_scan_done is 213 cycles after latch rise; next latch rises SCAN_GAP cycles after DONE.
// - T3: pad1 alternates 0x01/0x00 every scan. -> o_jp_vec_1p never leaves 0 (debounce).
//   -> then hold 0x02 for 2 scans -> 10'h002.
// - T4: pad1 holds U+D+A (0x31). -> o_jp_vec_1p=10'h001.
//   -> pad1 holds L+R+B (0xC2) -> o_jp_vec_1p=10'h002.
// - T5: assert i_rst in the CLK_LO of bit 4.
//   -> next cycle o_pad_clk=1, o_pad_latch=0, vectors=0.
//   -> after release, the first latch comes after SCAN_GAP cycles and scans decode correctly.
// - T6 (JPD_TURBO_EN): i_turbo_1p=2'b01 held for 32 scans.
//   -> o_jp_vec_1p[8] toggles every 8 scans; bit 9 stays 0.
//   -> without the macro, both stay 0.

Source files
------------

// File: rtl/joypad_scanner.sv
// Dual NES (4021) controller scanner with debounce and opposite-direction masking.
// Optional turbo A/B outputs on bits [9:8] are enabled by defining JPD_TURBO_EN.
module joypad_scanner #(
    parameter int unsigned CLK_DIV  = 12,
    parameter int unsigned SCAN_GAP = 30000,
    parameter int unsigned DEB_CNT  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_pad_latch,
    output logic       o_pad_clk,
    input  logic       i_pad_data_1p,
    input  logic       i_pad_data_2p,
    input  logic [1:0] i_turbo_1p,
    input  logic [1:0] i_turbo_2p,
    output logic [9:0] o_jp_vec_1p,
    output logic [9:0] o_jp_vec_2p,
    output logic       o_scan_done
);

    typedef enum logic [2:0] {
        ST_GAP,
        ST_LATCH,
        ST_SETTLE,
        ST_SAMPLE,
        ST_CLK_LO,
        ST_CLK_HI,
        ST_DONE
    } state_t;

    localparam int unsigned TMAX = (SCAN_GAP > 2 * CLK_DIV) ? SCAN_GAP : 2 * CLK_DIV;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] GAP_LAST   = TW'(SCAN_GAP - 1);
    localparam logic [TW-1:0] LATCH_LAST = TW'(2 * CLK_DIV - 1);
    localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
    localparam logic [2:0]    DEB_TGT    = 3'(DEB_CNT);

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    sync_1p_q, sync_1p_d;
    logic [1:0]    sync_2p_q, sync_2p_d;
    logic [7:0]    cap_1p_q, cap_1p_d;
    logic [7:0]    cap_2p_q, cap_2p_d;
    logic [7:0]    prev_1p_q, prev_1p_d;
    logic [7:0]    prev_2p_q, prev_2p_d;
    logic [2:0]    cnt_1p_q, cnt_1p_d;
    logic [2:0]    cnt_2p_q, cnt_2p_d;
    logic [7:0]    vec_1p_q, vec_1p_d;
    logic [7:0]    vec_2p_q, vec_2p_d;
    logic          latch_q, latch_d;
    logic          pclk_q, pclk_d;
    logic          done_q, done_d;

    function automatic logic [2:0] next_cnt(input logic [7:0] cap, input logic [7:0] prev,
                                            input logic [2:0] cnt);
        if (cap != prev) return 3'd1;
        else if (cnt >= DEB_TGT) return DEB_TGT;
        else return cnt + 3'd1;
    endfunction

    // Bit map: [4]=U [5]=D [6]=L [7]=R; opposing pairs cancel out.
    function automatic logic [7:0] resolve(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[4] && v[5]) r[5:4] = 2'b00;
        if (v[6] && v[7]) r[7:6] = 2'b00;
        return r;
    endfunction

    assign sync_1p_d = {sync_1p_q[0], i_pad_data_1p};
    assign sync_2p_d = {sync_2p_q[0], i_pad_data_2p};

`ifdef JPD_TURBO_EN
    logic [3:0] rate_q, rate_d;
    logic [1:0] tb_1p_q, tb_1p_d;
    logic [1:0] tb_2p_q, tb_2p_d;

    always_comb begin
        rate_d  = rate_q;
        tb_1p_d = tb_1p_q;
        tb_2p_d = tb_2p_q;
        if (state_q == ST_DONE) begin
            rate_d  = rate_q + 4'd1;
            tb_1p_d = i_turbo_1p & {2{rate_d[3]}};
            tb_2p_d = i_turbo_2p & {2{rate_d[3]}};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rate_q  <= '0;
            tb_1p_q <= '0;
            tb_2p_q <= '0;
        end else begin
            rate_q  <= rate_d;
            tb_1p_q <= tb_1p_d;
            tb_2p_q <= tb_2p_d;
        end
    end

    assign o_jp_vec_1p = {tb_1p_q, vec_1p_q};
    assign o_jp_vec_2p = {tb_2p_q, vec_2p_q};
`else
    logic unused_turbo;
    assign unused_turbo = ^{i_turbo_1p, i_turbo_2p};
    assign o_jp_vec_1p  = {2'b00, vec_1p_q};
    assign o_jp_vec_2p  = {2'b00, vec_2p_q};
`endif

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        cap_1p_d  = cap_1p_q;
        cap_2p_d  = cap_2p_q;
        prev_1p_d = prev_1p_q;
        prev_2p_d = prev_2p_q;
        cnt_1p_d  = cnt_1p_q;
        cnt_2p_d  = cnt_2p_q;
        vec_1p_d  = vec_1p_q;
        vec_2p_d  = vec_2p_q;
        case (state_q)
            ST_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = ST_LATCH;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_LATCH: begin
                if (tmr_q == LATCH_LAST) begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_SETTLE: begin
                if (tmr_q == DIV_LAST) begin
                    state_d = ST_SAMPLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_SAMPLE: begin
                cap_1p_d[bit_q] = ~sync_1p_q[1];
                cap_2p_d[bit_q] = ~sync_2p_q[1];
                tmr_d           = '0;
                state_d         = (bit_q == 3'd7) ? ST_DONE : ST_CLK_LO;
            end
            ST_CLK_LO: begin
                if (tmr_q == DIV_LAST) begin
                    state_d = ST_CLK_HI;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_CLK_HI: begin
                if (tmr_q == DIV_LAST) begin
                    state_d = ST_SAMPLE;
                    tmr_d   = '0;
                    bit_d   = bit_q + 3'd1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d   = ST_GAP;
                tmr_d     = '0;
                bit_d     = '0;
                prev_1p_d = cap_1p_q;
                prev_2p_d = cap_2p_q;
                cnt_1p_d  = next_cnt(cap_1p_q, prev_1p_q, cnt_1p_q);
                cnt_2p_d  = next_cnt(cap_2p_q, prev_2p_q, cnt_2p_q);
                if (cnt_1p_d == DEB_TGT) vec_1p_d = resolve(cap_1p_q);
                if (cnt_2p_d == DEB_TGT) vec_2p_d = resolve(cap_2p_q);
            end
            default: begin
                state_d = ST_GAP;
                tmr_d   = '0;
                bit_d   = '0;
            end
        endcase
        // Pad lines are registered from the next state so they stay glitch-free yet align with state_q.
        latch_d = (state_d == ST_LATCH);
        pclk_d  = (state_d != ST_CLK_LO);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_GAP;
            tmr_q     <= '0;
            bit_q     <= '0;
            sync_1p_q <= '1;
            sync_2p_q <= '1;
            cap_1p_q  <= '0;
            cap_2p_q  <= '0;
            prev_1p_q <= '0;
            prev_2p_q <= '0;
            cnt_1p_q  <= '0;
            cnt_2p_q  <= '0;
            vec_1p_q  <= '0;
            vec_2p_q  <= '0;
            latch_q   <= 1'b0;
            pclk_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_q     <= bit_d;
            sync_1p_q <= sync_1p_d;
            sync_2p_q <= sync_2p_d;
            cap_1p_q  <= cap_1p_d;
            cap_2p_q  <= cap_2p_d;
            prev_1p_q <= prev_1p_d;
            prev_2p_q <= prev_2p_d;
            cnt_1p_q  <= cnt_1p_d;
            cnt_2p_q  <= cnt_2p_d;
            vec_1p_q  <= vec_1p_d;
            vec_2p_q  <= vec_2p_d;
            latch_q   <= latch_d;
            pclk_q    <= pclk_d;
            done_q    <= done_d;
        end
    end

    assign o_pad_latch = latch_q;
    assign o_pad_clk   = pclk_q;
    assign o_scan_done = done_q;

endmodule

// File: tb/tb_joypad_scanner.sv
// Scoreboard bench for joypad_scanner: 4021 pad models, queued expectations, timing monitor.
module tb_joypad_scanner;

    localparam int unsigned CD   = 12;
    localparam int unsigned GAP  = 50;
    localparam int unsigned DEB  = 2;
    localparam int unsigned LAT  = 2 * CD + CD + 8 + 14 * CD + 1;
    localparam int unsigned WAIT = 4 * (GAP + LAT + 20);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       o_pad_latch, o_pad_clk, o_scan_done;
    logic       pad_data_1p, pad_data_2p;
    logic [1:0] turbo_1p = 2'b00;
    logic [1:0] turbo_2p = 2'b00;
    logic [9:0] o_jp_vec_1p, o_jp_vec_2p;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    joypad_scanner #(.CLK_DIV(CD), .SCAN_GAP(GAP), .DEB_CNT(DEB)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_pad_latch  (o_pad_latch),
        .o_pad_clk    (o_pad_clk),
        .i_pad_data_1p(pad_data_1p),
        .i_pad_data_2p(pad_data_2p),
        .i_turbo_1p   (turbo_1p),
        .i_turbo_2p   (turbo_2p),
        .o_jp_vec_1p  (o_jp_vec_1p),
        .o_jp_vec_2p  (o_jp_vec_2p),
        .o_scan_done  (o_scan_done)
    );

    // 4021 pad models: parallel load on latch, shift toward the output on each clock rise.
    logic [7:0] btn_1p = 8'h00, btn_2p = 8'h00;
    logic       disc_1p = 1'b0, disc_2p = 1'b0;
    logic [7:0] sr_1p = 8'h00, sr_2p = 8'h00;

    always @(posedge o_pad_latch or posedge o_pad_clk) begin
        if (o_pad_latch) begin
            sr_1p <= btn_1p;
            sr_2p <= btn_2p;
        end else begin
            sr_1p <= {1'b0, sr_1p[7:1]};
            sr_2p <= {1'b0, sr_2p[7:1]};
        end
    end

    assign pad_data_1p = disc_1p ? 1'b1 : ~sr_1p[0];
    assign pad_data_2p = disc_2p ? 1'b1 : ~sr_2p[0];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a vector follows the pad once DEB identical scans in a row have been seen.
    logic [7:0]  hist [2][$];
    logic [7:0]  deb_m [2];
    int          scans = 0;
    logic [19:0] exp_q [$];

    task automatic model_reset();
        hist[0].delete();
        hist[1].delete();
        deb_m[0] = 8'h00;
        deb_m[1] = 8'h00;
        scans    = 0;
        exp_q.delete();
    endtask

    task automatic issue(input logic [7:0] b1, input logic [7:0] b2, input logic d1,
                         input logic d2, input logic [1:0] t1, input logic [1:0] t2);
        logic [7:0] raw [2];
        logic [1:0] tb  [2];
        logic [9:0] e   [2];
        bit         stable;
        bit         phase;
        btn_1p   = b1;
        btn_2p   = b2;
        disc_1p  = d1;
        disc_2p  = d2;
        turbo_1p = t1;
        turbo_2p = t2;
        raw[0]   = d1 ? 8'h00 : b1;
        raw[1]   = d2 ? 8'h00 : b2;
        tb[0]    = t1;
        tb[1]    = t2;
        scans++;
        phase = ((scans % 16) >= 8);
        for (int p = 0; p < 2; p++) begin
            hist[p].push_back(raw[p]);
            if (hist[p].size() > DEB) void'(hist[p].pop_front());
            stable = (hist[p].size() == DEB);
            foreach (hist[p][k]) if (hist[p][k] != raw[p]) stable = 0;
            if (stable) deb_m[p] = raw[p];
            e[p][7:0] = deb_m[p];
            if (deb_m[p][4] && deb_m[p][5]) e[p][5:4] = 2'b00;
            if (deb_m[p][6] && deb_m[p][7]) e[p][7:6] = 2'b00;
`ifdef JPD_TURBO_EN
            e[p][9:8] = phase ? tb[p] : 2'b00;
`else
            e[p][9:8] = (phase && 1'b0) ? tb[p] : 2'b00;
`endif
        end
        exp_q.push_back({e[1], e[0]});
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < WAIT; i++) begin
            @(negedge clk);
            if (o_scan_done) break;
        end
        if (i == WAIT) chk("scan_done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic scan(input logic [7:0] b1, input logic [7:0] b2, input logic d1,
                        input logic d2, input logic [1:0] t1, input logic [1:0] t2);
        issue(b1, b2, d1, d2, t1, t2);
        wait_done();
    endtask

    // Vector monitor: pops one expectation per completed scan.
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (!rst && o_scan_done) begin
                @(negedge clk);
                chk("scan_done_one_cycle", int'(o_scan_done), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_scan", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("vec_1p", int'(o_jp_vec_1p), int'(e[9:0]));
                    chk("vec_2p", int'(o_jp_vec_2p), int'(e[19:10]));
                end
            end
        end
    end

    // Timing monitor: latch width, pad-clock pulse count, latch-to-done latency, inter-scan gap.
    initial begin
        int cyc = 0, t_rise = 0, t_done = 0, lat_len = 0, lows = 0;
        bit in_scan = 0, have_done = 0, latch_p = 0, pclk_p = 1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_scan   = 0;
                have_done = 0;
                latch_p   = 0;
                pclk_p    = 1;
            end else begin
                if (o_pad_latch && !latch_p) begin
                    t_rise  = cyc;
                    lat_len = 0;
                    lows    = 0;
                    in_scan = 1;
                    if (have_done) chk("gap_cycles", t_rise - t_done - 1, GAP);
                end
                if (o_pad_latch) lat_len++;
                if (!o_pad_clk && pclk_p) lows++;
                if (o_scan_done && in_scan) begin
                    chk("latch_width", lat_len, 2 * CD);
                    chk("clk_low_pulses", lows, 7);
                    chk("latch_to_done", cyc - t_rise + 1, LAT);
                    t_done    = cyc;
                    have_done = 1;
                    in_scan   = 0;
                end
                latch_p = o_pad_latch;
                pclk_p  = o_pad_clk;
            end
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_latch"}, int'(o_pad_latch), 0);
        chk({tag, "_pclk"}, int'(o_pad_clk), 1);
        chk({tag, "_vec_1p"}, int'(o_jp_vec_1p), 0);
        chk({tag, "_vec_2p"}, int'(o_jp_vec_2p), 0);
        chk({tag, "_done"}, int'(o_scan_done), 0);
    endtask

    initial begin
        logic [7:0] r1, r2;
        int falls, n;
        bit pprev;
        model_reset();
        repeat (3) @(negedge clk);
        chk_idle("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // A+Start / Right, needs two matching scans
        scan(8'h09, 8'h80, 0, 0, 2'b00, 2'b00);
        scan(8'h09, 8'h80, 0, 0, 2'b00, 2'b00);

        // Alternating input never debounces, then a held value does
        for (int i = 0; i < 6; i++) scan((i % 2 == 0) ? 8'h01 : 8'h00, 8'h00, 0, 0, 2'b00, 2'b00);
        scan(8'h02, 8'h00, 0, 0, 2'b00, 2'b00);
        scan(8'h02, 8'h00, 0, 0, 2'b00, 2'b00);

        // Opposite directions
        scan(8'h31, 8'hC2, 0, 0, 2'b00, 2'b00);
        scan(8'h31, 8'hC2, 0, 0, 2'b00, 2'b00);
        scan(8'hC2, 8'hF0, 0, 0, 2'b00, 2'b00);
        scan(8'hC2, 8'hF0, 0, 0, 2'b00, 2'b00);

        // Disconnected pads read as released
        scan(8'hFF, 8'h5A, 1, 1, 2'b00, 2'b00);
        scan(8'hFF, 8'h5A, 1, 1, 2'b00, 2'b00);

        // Turbo A held for 32 scans
        for (int i = 0; i < 32; i++) scan(8'h00, 8'h00, 0, 0, 2'b01, 2'($urandom_range(0, 3)));

        // Randomized traffic with frequent holds
        r1 = 8'h00;
        r2 = 8'h00;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0) r1 = 8'($urandom);
            if ($urandom_range(0, 2) != 0) r2 = 8'($urandom);
            scan(r1, r2, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        scan(8'h03, 8'h0C, 0, 0, 2'b00, 2'b00);
        scan(8'h03, 8'h0C, 0, 0, 2'b00, 2'b00);

        // Reset during CLK_LO of bit 4 (fifth low pulse)
        btn_1p = 8'hA5;
        btn_2p = 8'h3C;
        falls  = 0;
        pprev  = 1;
        for (int i = 0; i < WAIT && falls < 5; i++) begin
            @(negedge clk);
            if (pprev && !o_pad_clk) falls++;
            pprev = o_pad_clk;
        end
        chk("reset_point_found", falls, 5);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_idle("midscan_reset");
        model_reset();
        repeat (2) @(negedge clk);
        issue(8'h48, 8'h11, 0, 0, 2'b00, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        for (int i = 0; i < WAIT; i++) begin
            @(posedge clk);
            #1 n++;
            if (o_pad_latch) break;
        end
        chk("post_reset_first_latch", n, GAP);
        wait_done();
        scan(8'h48, 8'h11, 0, 0, 2'b00, 2'b00);
        scan(8'h48, 8'h11, 0, 0, 2'b00, 2'b00);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
